// File: rtl/ines_pkg.sv
// Shared types and constants for the iNES stream loader.
// Optional build macro: INES_TRAINER_SKIP_EN (used by ines_stream_loader).
package ines_pkg;

  typedef enum logic [2:0] {
    ST_HEADER,
    ST_TRAINER,
    ST_PRG,
    ST_CHR,
    ST_DONE,
    ST_ERROR
  } ines_state_e;

  localparam logic [31:0] INES_MAGIC = 32'h4E45531A;

  localparam int PRG_BANK_BYTES = 16384;
  localparam int CHR_BANK_BYTES = 8192;
  localparam int TRAINER_BYTES  = 512;

  localparam int PRG_SHIFT = $clog2(PRG_BANK_BYTES);
  localparam int CHR_SHIFT = $clog2(CHR_BANK_BYTES);

  // mapper_flags field positions
  localparam int MF_MAPPER_LSB  = 0;
  localparam int MF_PRG_LSB     = 8;
  localparam int MF_CHR_LSB     = 16;
  localparam int MF_VMIRROR     = 24;
  localparam int MF_BATTERY     = 25;
  localparam int MF_FOUR_SCREEN = 26;
  localparam int MF_CHR_RAM     = 27;

  // Expected magic byte for header positions 0..3 (big-endian order on the wire).
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = INES_MAGIC[31:24];
      2'd1:    b = INES_MAGIC[23:16];
      2'd2:    b = INES_MAGIC[15:8];
      default: b = INES_MAGIC[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ines_header_parser.sv
// Captures the interesting iNES header bytes (4..7), checks the magic bytes
// as they stream past, and assembles the raw configuration word.
module ines_header_parser
  import ines_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        hdr_we,
  input  logic [3:0]  byte_idx,
  input  logic [7:0]  byte_in,
  output logic        magic_ok,
  output logic        header_done,
  output logic [7:0]  prg_banks,
  output logic [7:0]  chr_banks,
  output logic        has_trainer,
  output logic [31:0] mapper_flags
);

  logic [7:0] h4_q, h4_d;
  logic [7:0] h5_q, h5_d;
  logic [7:0] h6_q, h6_d;
  logic [7:0] h7_q, h7_d;

  // Magic check on the byte currently presented; positions past 3 always pass.
  always_comb begin
    magic_ok    = (byte_idx > 4'd3) || (byte_in == magic_byte(byte_idx[1:0]));
    header_done = hdr_we && (byte_idx == 4'd15);
  end

  // Select which stored header byte the incoming byte replaces.
  always_comb begin
    h4_d = h4_q;
    h5_d = h5_q;
    h6_d = h6_q;
    h7_d = h7_q;
    if (hdr_we) begin
      case (byte_idx)
        4'd4:    h4_d = byte_in;
        4'd5:    h5_d = byte_in;
        4'd6:    h6_d = byte_in;
        4'd7:    h7_d = byte_in;
        default: ;
      endcase
    end
  end

  // Header byte storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      h4_q <= '0;
      h5_q <= '0;
      h6_q <= '0;
      h7_q <= '0;
    end else begin
      h4_q <= h4_d;
      h5_q <= h5_d;
      h6_q <= h6_d;
      h7_q <= h7_d;
    end
  end

  assign prg_banks   = h4_q;
  assign chr_banks   = h5_q;
  assign has_trainer = h6_q[2];

  // Assemble the configuration word from the stored bytes.
  always_comb begin
    mapper_flags                             = '0;
    mapper_flags[MF_MAPPER_LSB +: 8]         = {h7_q[7:4], h6_q[7:4]};
    mapper_flags[MF_PRG_LSB +: 8]            = h4_q;
    mapper_flags[MF_CHR_LSB +: 8]            = h5_q;
    mapper_flags[MF_VMIRROR]                 = h6_q[0];
    mapper_flags[MF_BATTERY]                 = h6_q[1];
    mapper_flags[MF_FOUR_SCREEN]             = h6_q[3];
    mapper_flags[MF_CHR_RAM]                 = (h5_q == 8'd0);
  end

endmodule

// File: rtl/ines_stream_loader.sv
// iNES stream loader: parses the 16-byte header, optionally skips the
// 512-byte trainer, then writes PRG and CHR data into the cartridge map
// one cycle after each accepted byte.
// Optional build macro: INES_TRAINER_SKIP_EN -- when undefined, a header
// announcing a trainer is rejected with error.
module ines_stream_loader
  import ines_pkg::*;
#(
  parameter logic [21:0] PRG_BASE      = 22'h000000,
  parameter logic [21:0] CHR_BASE      = 22'h200000,
  parameter int          MAX_PRG_BANKS = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  indata,
  input  logic        indata_clk,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_write,
  output logic [31:0] mapper_flags,
  output logic        flags_valid,
  output logic        done,
  output logic        error
);

`ifdef INES_TRAINER_SKIP_EN
  localparam bit TRAINER_EN = 1'b1;
`else
  localparam bit TRAINER_EN = 1'b0;
`endif

  localparam logic [21:0] TRAINER_LAST = 22'(TRAINER_BYTES - 1);

  ines_state_e state_q, state_d;
  logic [3:0]  hdr_idx_q, hdr_idx_d;
  logic [21:0] off_q, off_d;
  logic [21:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_data_q, mem_data_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] flags_q, flags_d;
  logic        flags_valid_q, flags_valid_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        accept, hdr_we;
  logic        magic_ok, header_done, has_trainer, banks_bad;
  logic [7:0]  prg_banks, chr_banks;
  logic [31:0] hdr_flags;
  logic [21:0] prg_last, chr_last;

  assign accept = indata_clk && (state_q != ST_DONE) && (state_q != ST_ERROR);
  assign hdr_we = accept && (state_q == ST_HEADER);

  ines_header_parser u_hdr (
    .clk          (clk),
    .reset        (reset),
    .hdr_we       (hdr_we),
    .byte_idx     (hdr_idx_q),
    .byte_in      (indata),
    .magic_ok     (magic_ok),
    .header_done  (header_done),
    .prg_banks    (prg_banks),
    .chr_banks    (chr_banks),
    .has_trainer  (has_trainer),
    .mapper_flags (hdr_flags)
  );

  // Region sizes as last valid offsets; banks are range-checked before use,
  // so PRG never wraps and CHR (max 255 banks) always fits in 22 bits.
  always_comb begin
    prg_last  = (22'(prg_banks) << PRG_SHIFT) - 22'd1;
    chr_last  = (22'(chr_banks) << CHR_SHIFT) - 22'd1;
    banks_bad = (prg_banks == 8'd0) || (int'(prg_banks) > MAX_PRG_BANKS);
  end

  // Next-state and registered-output logic for the load sequence.
  always_comb begin
    state_d       = state_q;
    hdr_idx_d     = hdr_idx_q;
    off_d         = off_q;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    mem_write_d   = 1'b0;
    flags_d       = flags_q;
    flags_valid_d = flags_valid_q;
    done_d        = done_q;
    error_d       = error_q;
    if (accept) begin
      unique case (state_q)
        ST_HEADER: begin
          hdr_idx_d = hdr_idx_q + 4'd1;
          if (!magic_ok) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else if (header_done) begin
            if (banks_bad || (has_trainer && !TRAINER_EN)) begin
              state_d = ST_ERROR;
              error_d = 1'b1;
            end else begin
              flags_valid_d = 1'b1;
              flags_d       = hdr_flags;
              off_d         = '0;
              state_d       = has_trainer ? ST_TRAINER : ST_PRG;
            end
          end
        end
        ST_TRAINER: begin
          if (off_q == TRAINER_LAST) begin
            off_d   = '0;
            state_d = ST_PRG;
          end else begin
            off_d = off_q + 22'd1;
          end
        end
        ST_PRG: begin
          mem_write_d = 1'b1;
          mem_addr_d  = PRG_BASE + off_q;
          mem_data_d  = indata;
          if (off_q == prg_last) begin
            off_d = '0;
            if (chr_banks != 8'd0) begin
              state_d = ST_CHR;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            off_d = off_q + 22'd1;
          end
        end
        ST_CHR: begin
          mem_write_d = 1'b1;
          mem_addr_d  = CHR_BASE + off_q;
          mem_data_d  = indata;
          if (off_q == chr_last) begin
            off_d   = '0;
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            off_d = off_q + 22'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, counters and outputs; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_HEADER;
      hdr_idx_q     <= '0;
      off_q         <= '0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      mem_write_q   <= 1'b0;
      flags_q       <= '0;
      flags_valid_q <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_idx_q     <= hdr_idx_d;
      off_q         <= off_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      mem_write_q   <= mem_write_d;
      flags_q       <= flags_d;
      flags_valid_q <= flags_valid_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_data     = mem_data_q;
  assign mem_write    = mem_write_q;
  assign mapper_flags = flags_q;
  assign flags_valid  = flags_valid_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule
